// File: rtl/class_vote_filter.sv
// Temporal majority-vote filter on the argmax class stream: keeps a sliding
// window of class samples and reports a new stable winner over valid/ready.
module class_vote_filter #(
    parameter int WINDOW = 8,
    parameter int THRESH = 5,
    localparam int CW = $clog2(WINDOW) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sample_en,
    input  logic [1:0]    class_idx,
    input  logic          class_changed,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_class,
    output logic [CW-1:0] out_votes,
    output logic          window_full,
    output logic [15:0]   change_count
);

    // state  | meaning
    // FILL   | window not yet full, accumulating samples
    // TRACK  | window full, looking for a new qualifying winner
    // REPORT | report pending, payload frozen until handshake
    typedef enum logic [1:0] {FILL, TRACK, REPORT} state_t;

    localparam int AW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    state_t          state, state_nxt;
    logic [1:0]      hist [WINDOW];
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   fill;
    logic [CW-1:0]   cnt [4];
    logic [CW-1:0]   cnt_nxt [4];
    logic [1:0]      oldest;
    logic            accept;
    logic            full;
    logic [1:0]      win;
    logic [CW-1:0]   win_cnt;
    logic            qualify;
    logic            latch;
    logic [1:0]      last_reported;
    logic            last_valid;

    assign accept      = sample_en && !flush;
    assign full        = (fill == CW'(WINDOW));
    assign oldest      = hist[wr_ptr];
    assign window_full = full;
    assign out_valid   = (state == REPORT);

    // When the window is full wr_ptr points at the oldest entry, which is evicted.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cnt_nxt[c] = cnt[c];
            if (accept) begin
                if (2'(c) == class_idx)
                    cnt_nxt[c] = cnt_nxt[c] + CW'(1);
                if (full && 2'(c) == oldest)
                    cnt_nxt[c] = cnt_nxt[c] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            fill   <= '0;
            for (int c = 0; c < 4; c++) cnt[c] <= '0;
            for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            fill   <= '0;
            for (int c = 0; c < 4; c++) cnt[c] <= '0;
            for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
        end else if (accept) begin
            hist[wr_ptr] <= class_idx;
            wr_ptr       <= wr_ptr + AW'(1);
            if (!full)
                fill <= fill + CW'(1);
            for (int c = 0; c < 4; c++) cnt[c] <= cnt_nxt[c];
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        win     = 2'd0;
        win_cnt = cnt[0];
        for (int c = 1; c < 4; c++) begin
            if (cnt[c] > win_cnt) begin
                win     = 2'(c);
                win_cnt = cnt[c];
            end
        end
    end

    assign qualify = (win_cnt >= CW'(THRESH)) && (!last_valid || win != last_reported);

    // FILL hands over to TRACK on the edge that stores the last filling sample,
    // so TRACK judges the full window in the very next cycle.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            FILL: begin
                if (full || (accept && fill == CW'(WINDOW - 1)))
                    state_nxt = TRACK;
            end
            TRACK: begin
                if (qualify) begin
                    state_nxt = REPORT;
                    latch     = 1'b1;
                end
            end
            REPORT: begin
                if (out_ready)
                    state_nxt = TRACK;
            end
            default: state_nxt = FILL;
        endcase
        if (flush) begin
            state_nxt = FILL;
            latch     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FILL;
            out_class     <= '0;
            out_votes     <= '0;
            last_reported <= '0;
            last_valid    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                last_valid <= 1'b0;
            end else if (latch) begin
                out_class     <= win;
                out_votes     <= win_cnt;
                last_reported <= win;
                last_valid    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            change_count <= '0;
        else if (class_changed && change_count != 16'hFFFF)
            change_count <= change_count + 16'd1;
    end

endmodule

// File: doc/class_vote_filter.md
# class_vote_filter

Temporal majority-vote filter directly downstream of the final dense/argmax stage. It samples the 2-bit winning class index on each inference strobe and holds the last WINDOW samples in a history buffer. It reports a class over a valid/ready handshake only when that class wins the window with at least THRESH votes and differs from the last reported class. It also counts upstream class-change pulses for diagnostics.

## Interface
- WINDOW, 8, samples in the vote window; power of two, 2..64
- THRESH, 5, minimum votes for a report; 1..WINDOW
- CW, $clog2(WINDOW)+1, derived width of vote counts (not overridable)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- sample_en  in  1  one-cycle strobe; class_idx is valid this cycle
- class_idx  in  2  upstream argmax class (0..3)
- class_changed  in  1  upstream one-cycle change pulse, counted only
- flush  in  1  synchronous clear of window and pending report
- out_valid  out  1  report available
- out_ready  in  1  consumer accepts report
- out_class  out  2  reported class
- out_votes  out  CW  votes of out_class at decision time
- window_full  out  1  history holds WINDOW samples
- change_count  out  16  saturating count of class_changed pulses

## Operation
- Reset (reset_n low, async): all outputs 0; history, four vote counters, fill counter and last_reported cleared; last_valid = 0; state FILL.
- History: circular buffer of WINDOW 2-bit entries with write pointer wr_ptr that wraps WINDOW-1 -> 0.
- On sample_en with fill < WINDOW: count[class_idx]++, fill++, write entry.
- On sample_en with fill == WINDOW: count[oldest]--, count[class_idx]++ (net zero when equal), overwrite oldest, advance pointer.
- Invariant: sum of counts == fill. No counter may exceed WINDOW or underflow.
- Winner is the class with the highest count. Ties resolve to the lowest index.
- States:
  - FILL: accumulate. Go to TRACK when fill reaches WINDOW.
  - TRACK: evaluated every cycle from the registered counts. Go to REPORT when winner count >= THRESH and (last_valid == 0 or winner != last_reported). On entry, latch out_class/out_votes and set last_reported = winner, last_valid = 1.
  - REPORT: out_valid = 1. out_class and out_votes are frozen until handshake. Samples continue to be accepted. On out_valid && out_ready, go to TRACK.
- A new qualifying winner may report in the cycle after a handshake.
- flush: from any state go to FILL. Clears history, counts, fill, wr_ptr, out_valid and last_valid. out_class/out_votes hold their value. flush beats sample_en in the same cycle, and that sample is discarded. flush beats a same-cycle handshake: the report counts as dropped.
- change_count: +1 per class_changed cycle. Saturates at 16'hFFFF. Cleared only by reset; flush does not clear it.
- window_full = (fill == WINDOW).

## Timing
- sample_en in cycle N: counts/fill are updated at the N edge and visible in N+1.
- The decision registers at the N+1 edge, so out_valid is high in cycle N+2. Sample-to-report latency is 2 cycles.
- out_valid may rise only from TRACK. Once high, it stays high with stable payload until the cycle where out_ready = 1, then drops the next cycle.
- out_ready while out_valid = 0 is ignored.
- window_full rises in the cycle after the WINDOW-th accepted sample.
- Back-to-back sample_en every cycle is supported. No sample is ever dropped except under flush.

## Test plan
- Reset with reset_n low mid-REPORT (out_valid = 1): out_valid, out_class, out_votes, window_full and change_count read 0 immediately, before the next clk edge.
- Reset, out_ready = 1, then 8 consecutive sample_en with class 2: window_full = 1 one cycle after the 8th sample; out_valid = 1 two cycles after the 8th sample with out_class = 2, out_votes = 8, for exactly one cycle. A further 8 samples of class 2 produce no report.
- Window fill of 4×class 1 then 4×class 3: winner = 1 with 4 votes < THRESH, so no report. Then 1 more class 3 sample evicts one class 1 (counts: class 1 = 3, class 3 = 5): report class 3, votes 5.
- Backpressure: report class 2 with out_ready = 0, then 8 samples of class 0. out_class stays 2 and out_votes stays 8 throughout. Raise out_ready for one cycle: out_valid falls, then rises the next cycle with class 0, votes 8.
- flush asserted together with sample_en and out_ready while in REPORT: next cycle out_valid = 0, window_full = 0, fill = 0. The sample is not counted. The next 8 samples of class 2 re-report class 2 because last_valid was cleared.
- 70000 class_changed pulses: change_count = 16'hFFFF and stays there. A flush leaves it at 16'hFFFF.
